// File: rtl/core_pmp_checker.sv
`timescale 1ns/1ps
// core_pmp_checker: sequential PMP checker shared between the instruction and
// data ports. A round-robin arbiter grants one check at a time; the granted
// request is compared against one PMP region per cycle, lowest index first.
module core_pmp_checker #(
  parameter int unsigned ADDR_WIDTH  = 56,
  parameter int unsigned NUM_REGIONS = 8
) (
  input  logic                  f_clk,
  input  logic                  g_resetn,
  input  logic                  imem_req,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [1:0]            imem_prv,
  output logic                  imem_ack,
  output logic                  imem_trap,
  input  logic                  dmem_req,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [1:0]            dmem_prv,
  input  logic                  dmem_wen,
  output logic                  dmem_ack,
  output logic                  dmem_trap,
  output logic [5:0]            rd_idx,
  input  logic [7:0]            rd_cfg,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  typedef enum logic [1:0] {A_OFF, A_TOR, A_NA4, A_NAPOT} amode_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_REGIONS - 1);
  localparam logic [1:0] PRV_M    = 2'b10;

  state_t                state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] prev_addr_q, prev_addr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  prv_m_q, prv_m_d;
  logic                  wen_q, wen_d;
  logic                  port_q, port_d;       // 0 = imem, 1 = dmem
  logic                  rr_last_q, rr_last_d; // last granted port, same encoding
  logic                  imem_ack_q, imem_ack_d;
  logic                  dmem_ack_q, dmem_ack_d;
  logic                  imem_trap_q, imem_trap_d;
  logic                  dmem_trap_q, dmem_trap_d;
  logic                  busy_q, busy_d;

  amode_t amode;
  logic   region_match;
  logic   perm_bit;
  logic   permitted;
  logic   grant_dmem;
  logic   result;
  logic   unused_cfg;

  assign unused_cfg = ^rd_cfg[6:5];

  // Evaluate the region currently presented on the read port against the latched request.
  always_comb begin
    amode        = amode_t'(rd_cfg[4:3]);
    region_match = 1'b0;
    unique case (amode)
      A_OFF:   region_match = 1'b0;
      A_TOR:   region_match = (prev_addr_q <= addr_q) && (addr_q < rd_addr);
      A_NA4:   region_match = (rd_addr == addr_q);
      A_NAPOT: region_match = ((rd_addr & addr_q) == addr_q) && ((rd_addr | addr_q) == rd_addr);
      default: region_match = 1'b0;
    endcase
    perm_bit  = port_q ? (wen_q ? rd_cfg[1] : rd_cfg[0]) : rd_cfg[2];
    permitted = (prv_m_q && !rd_cfg[7]) || perm_bit;
  end

  // Next-state logic: arbitration in IDLE, region scan in SCAN, one-cycle ack in RESP.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    prev_addr_d = prev_addr_q;
    addr_d      = addr_q;
    prv_m_d     = prv_m_q;
    wen_d       = wen_q;
    port_d      = port_q;
    rr_last_d   = rr_last_q;
    imem_ack_d  = 1'b0;
    dmem_ack_d  = 1'b0;
    imem_trap_d = 1'b0;
    dmem_trap_d = 1'b0;
    result      = 1'b0;
    grant_dmem  = dmem_req && (!imem_req || !rr_last_q);

    unique case (state_q)
      IDLE: begin
        if (imem_req || dmem_req) begin
          port_d      = grant_dmem;
          rr_last_d   = grant_dmem;
          addr_d      = grant_dmem ? dmem_addr : imem_addr;
          prv_m_d     = (grant_dmem ? dmem_prv : imem_prv) == PRV_M;
          wen_d       = grant_dmem && dmem_wen;
          idx_d       = '0;
          prev_addr_d = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (region_match || (idx_q == LAST_IDX)) begin
          result      = region_match ? !permitted : !prv_m_q;
          imem_ack_d  = !port_q;
          dmem_ack_d  = port_q;
          imem_trap_d = !port_q && result;
          dmem_trap_d = port_q && result;
          state_d     = RESP;
        end else begin
          prev_addr_d = rd_addr;
          idx_d       = idx_q + 6'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any scan without an ack.
  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      prev_addr_q <= '0;
      addr_q      <= '0;
      prv_m_q     <= 1'b0;
      wen_q       <= 1'b0;
      port_q      <= 1'b0;
      rr_last_q   <= 1'b0;
      imem_ack_q  <= 1'b0;
      dmem_ack_q  <= 1'b0;
      imem_trap_q <= 1'b0;
      dmem_trap_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      prev_addr_q <= prev_addr_d;
      addr_q      <= addr_d;
      prv_m_q     <= prv_m_d;
      wen_q       <= wen_d;
      port_q      <= port_d;
      rr_last_q   <= rr_last_d;
      imem_ack_q  <= imem_ack_d;
      dmem_ack_q  <= dmem_ack_d;
      imem_trap_q <= imem_trap_d;
      dmem_trap_q <= dmem_trap_d;
      busy_q      <= busy_d;
    end
  end

  assign imem_ack  = imem_ack_q;
  assign dmem_ack  = dmem_ack_q;
  assign imem_trap = imem_trap_q;
  assign dmem_trap = dmem_trap_q;
  assign busy      = busy_q;
  assign rd_idx    = idx_q;

endmodule

// File: doc/core_pmp_checker.md
# core_pmp_checker

Sequential PMP checker that shares a single region comparator between the instruction and data ports. Checks are granted through a round-robin arbiter. The checker then scans the PMP region registers one region per cycle in priority order and stops at the first match. It sits between the fetch/LSU request paths and the PMP register file, which it reads through a single indexed read port. It trades check latency for area compared with a fully parallel match array.

## Interface
Parameters:
- ADDR_WIDTH, 56, physical address width (addresses are word-granular, as held in the pmpaddr registers).
- NUM_REGIONS, 8, number of implemented regions, legal range 1..64.

Ports:
- f_clk  in  1  free-running clock.
- g_resetn  in  1  asynchronous active-low reset.
- imem_req  in  1  instruction check request; held until imem_ack.
- imem_addr  in  ADDR_WIDTH  instruction address.
- imem_prv  in  2  privilege: 10 = M-mode, 01 = U-mode.
- imem_ack  out  1  one-cycle check-complete pulse.
- imem_trap  out  1  access fault; valid only while imem_ack=1.
- dmem_req  in  1  data check request; held until dmem_ack.
- dmem_addr  in  ADDR_WIDTH  data address.
- dmem_prv  in  2  privilege, same encoding as imem_prv.
- dmem_wen  in  1  0 = read, 1 = write.
- dmem_ack  out  1  one-cycle check-complete pulse.
- dmem_trap  out  1  access fault; valid only while dmem_ack=1.
- rd_idx  out  6  region index presented to the PMP register file.
- rd_cfg  in  8  pmpcfg[rd_idx], returned combinationally; bit fields are L[7], A[4:3], X[2], W[1], R[0].
- rd_addr  in  ADDR_WIDTH  pmpaddr[rd_idx], returned combinationally.
- busy  out  1  high whenever the checker is not in IDLE.

## Operation
- **FSM states:** IDLE, SCAN, RESP.
- **IDLE**
  - If any request is high, grant one requester. Latch its address, prv, wen and port ID.
  - Clear idx and the prev_addr register to 0, then go to SCAN.
- **Arbitration:** round-robin with a last-granted pointer.
  - The pointer resets to "imem", so dmem wins the first tie.
  - A lone requester is always granted.
  - The pointer updates on grant.
- **SCAN**
  - rd_idx = idx. Evaluate region idx against the latched request using A from rd_cfg:
    - OFF: never matches.
    - TOR: matches when prev_addr <= addr < rd_addr; top <= base never matches.
    - NA4: matches when rd_addr == addr.
    - NAPOT: matches when (rd_addr & addr) == addr and (rd_addr | addr) == rd_addr.
  - On a match, the access is permitted if it has the required permission: X for imem, R for a dmem read, W for a dmem write.
  - In M-mode with L=0, the access is permitted regardless of permissions.
  - Set result = !permitted and go to RESP. Lower index wins; higher regions are never examined after a match.
  - With no match: prev_addr <= rd_addr, idx <= idx+1.
  - At idx == NUM_REGIONS-1 with no match, go to RESP with the default result:
    - M-mode: permitted (result=0).
    - U-mode: fault (result=1).
- **RESP**
  - Assert ack on the latched port for exactly one cycle, with trap = result. The other port's ack and trap are 0.
  - Go to IDLE.
- **Requester rules:** a requester samples trap with ack. A req still high in the cycle after ack is treated as a new request.
- **Invalid privilege:** prv values other than 10/01 are treated as U-mode.
- **Reset values:**
  - State IDLE, idx 0, prev_addr 0, rr pointer imem.
  - All outputs 0: imem_ack, dmem_ack, imem_trap, dmem_trap, busy, rd_idx.
- **Reset mid-scan:** asynchronous return to IDLE with no ack issued. The requester re-requests after reset.
- **Register changes during a scan:** region registers that change mid-scan are used as read in each cycle; no snapshot is taken.

## Timing
- Request sampled high in IDLE at cycle 0 → SCAN runs from cycle 1.
- First match at region k → ack in cycle k+2.
- No match → ack in cycle NUM_REGIONS+1.
- Minimum request-to-request spacing is 3 cycles (IDLE, SCAN, RESP).
- A waiting requester is granted in the IDLE cycle that follows the other port's RESP.
- trap and ack are registered outputs; rd_idx is registered (= idx).
- No combinational path from any req to ack, trap, or rd_idx.

## Test plan
- **NAPOT fault, L set:** region0 NAPOT addr=0x1FF (512-word block at 0), cfg L=1 R=1 W=0; dmem write, addr=0x10, M-mode → dmem_ack in cycle 2 with dmem_trap=1. The same access as a read → trap=0.
- **TOR from zero:** region0 TOR addr=0x100, X=0, L=0; imem U-mode addr=0x80 → trap=1, ack cycle 2. The same request in M-mode → trap=0.
- **No-match default:** all 8 regions OFF, dmem U-mode read → ack in cycle 9, trap=1. The same read in M-mode → trap=0.
- **Priority:** region2 NA4 addr=0x40 with R=1, and region5 NAPOT covering 0x40 with R=0. U-mode read of 0x40 → ack cycle 4, trap=0; rd_idx never exceeds 2.
- **Arbitration:** imem_req and dmem_req raised together and held, each dropped after its own ack → dmem acked first, imem acked next. Repeat with both raised again → imem first. busy stays high except for one IDLE cycle between checks.
- **Reset mid-scan:** assert g_resetn=0 in cycle 3 of a scan → all outputs 0 asynchronously and no ack. After release, a held req is checked from idx 0 with correct latency.
